// File: rtl/idelay_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_ctrl_pkg
//   Shared definitions for the IDELAYE2 tap-sweep sequencer.
//   - state_e  : sequencer FSM states
//   - DEF_TAP_W/DEF_CNT_W : default tap and count widths
//   - result_t : one sweep result {tap, count} at the default widths
// ---------------------------------------------------------------------------
package clk_ctrl_pkg;

  localparam int unsigned DEF_TAP_W = 5;
  localparam int unsigned DEF_CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic [DEF_TAP_W-1:0] tap;
    logic [DEF_CNT_W-1:0] count;
  } result_t;

endpackage

// File: rtl/idelay_sweep_ctrl_sample_window_cnt.sv
// ---------------------------------------------------------------------------
// sample_window_cnt
//   Cycle counter plus high-sample counter for a programmable window.
//   Used by the sequencer both for the settle wait (samples ignored) and for
//   the measurement window.
// Ports
//   clk, rst       : clock, async active-high reset
//   i_clr          : clear cycle and sample counters (wins over i_en)
//   i_en           : advance the window by one cycle
//   i_sample       : count this cycle as high when i_en is set
//   i_len          : window length in cycles (>=1)
//   o_count        : samples counted so far (excludes the current cycle)
//   o_window_end   : high on the last enabled cycle of the window
// ---------------------------------------------------------------------------
module sample_window_cnt
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned CYC_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_sample,
  input  logic [CYC_W-1:0] i_len,
  output logic [CNT_W-1:0] o_count,
  output logic             o_window_end
);

  logic [CYC_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_count;

  assign o_window_end = i_en && (r_cyc == (i_len - CYC_W'(1)));
  assign o_count      = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc   <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_cyc   <= '0;
      r_count <= '0;
    end else if (i_en) begin
      r_cyc <= r_cyc + CYC_W'(1);
      if (i_sample) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/idelay_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// idelay_sweep_ctrl
//   Sweeps the IDELAYE2 (VAR_LOAD) tap from tap_first to tap_last. For each
//   tap: load, settle SETTLE_CYC cycles, count high samples of the delayed
//   clock over WINDOW_CYC cycles, report {tap, count}. A sweep only leaves
//   WAIT_RDY once the MMCM is locked and IDELAYCTRL is ready; losing lock
//   during a tap aborts the sweep with err set.
// Ports
//   clk, rst              : clock, async active-high reset
//   mmcm_locked, dly_rdy  : MMCM LOCKED, IDELAYCTRL RDY (clk domain)
//   start                 : 1-cycle sweep request (IDLE only)
//   tap_first, tap_last   : sweep range, sampled on accepted start
//   sample_in             : registered delayed clock
//   dly_cntvalue, dly_ld  : IDELAYE2 CNTVALUEIN / LD
//   busy                  : sweep in progress
//   res_valid/tap/count   : per-tap result strobe and data (held)
//   done                  : end-of-sweep strobe (normal or aborted)
//   err                   : sticky error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module idelay_sweep_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned TAP_W      = DEF_TAP_W,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned WINDOW_CYC = 256,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmcm_locked,
  input  logic             dly_rdy,
  input  logic             start,
  input  logic [TAP_W-1:0] tap_first,
  input  logic [TAP_W-1:0] tap_last,
  input  logic             sample_in,
  output logic [TAP_W-1:0] dly_cntvalue,
  output logic             dly_ld,
  output logic             busy,
  output logic             res_valid,
  output logic [TAP_W-1:0] res_tap,
  output logic [CNT_W-1:0] res_count,
  output logic             done,
  output logic             err
);

  localparam int unsigned MAX_CYC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int unsigned CYC_W   = $clog2(MAX_CYC + 1);

  state_e           r_state;
  state_e           w_next;
  logic [TAP_W-1:0] r_tap;
  logic [TAP_W-1:0] r_tap_last;
  logic [TAP_W-1:0] w_tap_nxt;
  logic             w_accept;
  logic             w_bad_range;
  logic             w_abort;

  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic [CYC_W-1:0] w_len;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_final;
  logic             w_window_end;

  logic [TAP_W-1:0] r_dly_cntvalue;
  logic             r_dly_ld;
  logic             r_busy;
  logic             r_res_valid;
  logic [TAP_W-1:0] r_res_tap;
  logic [CNT_W-1:0] r_res_count;
  logic             r_done;
  logic             r_err;

  sample_window_cnt #(
    .CNT_W (CNT_W),
    .CYC_W (CYC_W)
  ) u_win (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_cnt_clr),
    .i_en         (w_cnt_en),
    .i_sample     (sample_in && (r_state == ST_MEASURE)),
    .i_len        (w_len),
    .o_count      (w_count),
    .o_window_end (w_window_end)
  );

  // Counter output excludes the last window cycle; fold it in so the result
  // can be registered on the MEASURE->REPORT edge.
  assign w_count_final = w_count + CNT_W'(sample_in);

  always_comb begin
    w_next      = r_state;
    w_tap_nxt   = r_tap;
    w_accept    = 1'b0;
    w_bad_range = 1'b0;
    w_cnt_en    = (r_state == ST_SETTLE) || (r_state == ST_MEASURE);
    w_len       = (r_state == ST_SETTLE) ? CYC_W'(SETTLE_CYC) : CYC_W'(WINDOW_CYC);
    w_abort     = !mmcm_locked &&
                  (r_state inside {ST_LOAD, ST_SETTLE, ST_MEASURE, ST_REPORT});

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_bad_range = (tap_first > tap_last);
          w_tap_nxt   = tap_first;
          w_next      = w_bad_range ? ST_FIN : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: if (mmcm_locked && dly_rdy) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_SETTLE;
      ST_SETTLE:   if (w_window_end) w_next = ST_MEASURE;
      ST_MEASURE:  if (w_window_end) w_next = ST_REPORT;
      ST_REPORT: begin
        if (r_tap == r_tap_last) begin
          w_next = ST_FIN;
        end else begin
          w_next    = ST_LOAD;
          w_tap_nxt = r_tap + TAP_W'(1);
        end
      end
      ST_FIN:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase

    if (w_abort) begin
      w_next    = ST_FIN;
      w_tap_nxt = r_tap;
    end

    // Settle and measure share one counter: clear before settle and again
    // on the settle->measure boundary.
    w_cnt_clr = (r_state == ST_LOAD) || ((r_state == ST_SETTLE) && w_window_end);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Outputs registered from the next state so each strobe lines up exactly
  // with its state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap          <= '0;
      r_tap_last     <= '0;
      r_dly_cntvalue <= '0;
      r_dly_ld       <= 1'b0;
      r_busy         <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_tap      <= '0;
      r_res_count    <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_tap       <= w_tap_nxt;
      r_busy      <= !(w_next inside {ST_IDLE, ST_FIN});
      r_dly_ld    <= (w_next == ST_LOAD);
      r_res_valid <= (w_next == ST_REPORT);
      r_done      <= (w_next == ST_FIN);
      if (w_accept) r_tap_last <= tap_last;
      if (w_next == ST_LOAD) r_dly_cntvalue <= w_tap_nxt;
      if (w_next == ST_REPORT) begin
        r_res_tap   <= r_tap;
        r_res_count <= w_count_final;
      end
      if (w_accept)     r_err <= w_bad_range;
      else if (w_abort) r_err <= 1'b1;
    end
  end

  assign dly_cntvalue = r_dly_cntvalue;
  assign dly_ld       = r_dly_ld;
  assign busy         = r_busy;
  assign res_valid    = r_res_valid;
  assign res_tap      = r_res_tap;
  assign res_count    = r_res_count;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
module tb_idelay_sweep_ctrl;
  import clk_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mmcm_locked;
  logic       dly_rdy;
  logic       start;
  logic [4:0] tap_first;
  logic [4:0] tap_last;
  logic       sample_in = 1'b0;
  logic [4:0] dly_cntvalue;
  logic       dly_ld;
  logic       busy;
  logic       res_valid;
  logic [4:0] res_tap;
  logic [8:0] res_count;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;
  int n_ld  = 0;
  int n_res = 0;
  int cyc   = 0;
  int last_ld = 0;
  int smode = 0;
  result_t exp_q[$];
  result_t mon_e;

  always #5 clk = ~clk;

  idelay_sweep_ctrl #(
    .TAP_W      (5),
    .SETTLE_CYC (16),
    .WINDOW_CYC (256),
    .CNT_W      (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mmcm_locked  (mmcm_locked),
    .dly_rdy      (dly_rdy),
    .start        (start),
    .tap_first    (tap_first),
    .tap_last     (tap_last),
    .sample_in    (sample_in),
    .dly_cntvalue (dly_cntvalue),
    .dly_ld       (dly_ld),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_tap      (res_tap),
    .res_count    (res_count),
    .done         (done),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    n_cmp++;
    assert (cond) else begin
      n_err++;
      $error("FAIL %s: observed false expected true", tag);
    end
  endtask

  // sample_in: mode 0 constant high, mode 1 toggling (50% duty)
  always @(negedge clk) begin
    if (smode == 0) sample_in = 1'b1;
    else            sample_in = ~sample_in;
  end

  // Monitor: dly_ld spacing and scoreboard check of every result
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
    end else begin
      cyc++;
      if (dly_ld) begin
        n_ld++;
        if (n_ld > 1) chk("ld_gap", cyc - last_ld, 274);
        last_ld = cyc;
      end
      if (res_valid) begin
        n_res++;
        chk_true("res_expected", exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("res_tap", res_tap, mon_e.tap);
          chk("res_count", res_count, mon_e.count);
        end
      end
    end
  end

  task automatic push_exp(input int t, input int c);
    result_t e;
    e.tap   = 5'(t);
    e.count = 9'(c);
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int f, input int l);
    @(negedge clk);
    tap_first = 5'(f);
    tap_last  = 5'(l);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cntvalue"}, dly_cntvalue, 0);
    chk({tag, "_ld"}, dly_ld, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_tap"}, res_tap, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic run_sweep(input int f, input int l, input int mode, input bit check_lat);
    bit ok;
    smode = mode;
    n_ld  = 0;
    n_res = 0;
    for (int t = f; t <= l; t++) push_exp(t, (mode == 0) ? 256 : 128);
    do_start(f, l);
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, 0);
    if (check_lat) begin
      chk("ld_before_latency", dly_ld, 0);
      @(negedge clk);
      chk("ld_latency", dly_ld, 1);
      chk("ld_value", dly_cntvalue, f);
    end
    wait_done((l - f + 1) * 280 + 50, ok);
    chk_true("sweep_done_timeout", ok);
    chk("done_err", err, 0);
    chk("done_busy", busy, 0);
    chk("n_results", n_res, l - f + 1);
    chk("n_loads", n_ld, l - f + 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("cntvalue_hold", dly_cntvalue, l);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    mmcm_locked = 1'b1;
    dly_rdy = 1'b1;
    tap_first = '0;
    tap_last = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full sweeps: constant-high and 50% duty, including top tap without wrap
    run_sweep(3, 5, 0, 1'b1);
    run_sweep(31, 31, 1, 1'b1);
    run_sweep(10, 11, 1, 1'b0);

    // Gated start: not ready for 50 cycles, lock also low early on
    smode = 0; n_ld = 0; n_res = 0;
    push_exp(7, 256);
    dly_rdy = 1'b0;
    mmcm_locked = 1'b0;
    do_start(7, 7);
    for (int i = 0; i < 50; i++) begin
      chk("gated_busy", busy, 1);
      chk("gated_no_ld", dly_ld, 0);
      if (i == 20) mmcm_locked = 1'b1;
      @(negedge clk);
    end
    dly_rdy = 1'b1;
    chk("gated_ld_wait", dly_ld, 0);
    @(negedge clk);
    chk("gated_ld", dly_ld, 1);
    chk("gated_ld_value", dly_cntvalue, 7);
    wait_done(400, ok);
    chk_true("gated_done_timeout", ok);
    chk("gated_err", err, 0);
    chk("gated_n_res", n_res, 1);

    // Bad range: immediate done with err, no load, no result
    n_ld = 0; n_res = 0;
    do_start(9, 4);
    chk("bad_done", done, 1);
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bad_no_ld", dly_ld, 0);
      chk("bad_done_once", done, 0);
    end
    chk("bad_n_ld", n_ld, 0);
    chk("bad_n_res", n_res, 0);
    chk("bad_err_sticky", err, 1);

    // Lock loss in MEASURE of tap 1 during a 0..4 sweep
    smode = 0; n_ld = 0; n_res = 0;
    push_exp(0, 256);
    do_start(0, 4);
    chk("lock_err_cleared", err, 0);
    for (int i = 0; i < 700 && n_ld < 2; i++) @(negedge clk);
    chk("lock_second_ld", n_ld, 2);
    repeat (77) @(negedge clk);
    mmcm_locked = 1'b0;
    @(negedge clk);
    chk("lock_done", done, 1);
    chk("lock_err", err, 1);
    chk("lock_busy", busy, 0);
    mmcm_locked = 1'b1;
    chk("lock_n_res", n_res, 1);
    chk("lock_n_ld", n_ld, 2);
    chk("lock_cntvalue", dly_cntvalue, 1);
    chk("lock_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("lock_err_sticky", err, 1);
    chk("lock_done_once", done, 0);

    // Follow-up: start clears err; start while busy is ignored
    smode = 0; n_ld = 0; n_res = 0;
    push_exp(2, 256);
    do_start(2, 2);
    chk("follow_err_cleared", err, 0);
    repeat (30) @(negedge clk);
    do_start(20, 21);
    chk("follow_busy", busy, 1);
    wait_done(400, ok);
    chk_true("follow_done_timeout", ok);
    chk("follow_err", err, 0);
    chk("follow_n_res", n_res, 1);
    chk("follow_n_ld", n_ld, 1);
    chk("follow_cntvalue", dly_cntvalue, 2);
    repeat (10) begin
      @(negedge clk);
      chk("follow_idle", busy, 0);
    end

    // Asynchronous reset mid-sweep
    n_ld = 0; n_res = 0;
    push_exp(0, 256);
    push_exp(1, 256);
    do_start(0, 1);
    repeat (100) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_ld", dly_ld, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
